id_ex_elastic_reg: RTL and testbench
====================================

// Module: id_ex_elastic_reg
// PURPOSE
//  Parametrised ID->EX pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
//  Replaces the plain always-load ID/EX latch: EX back-pressure stalls without a combinational ready path.
//  Branch/exception flush squashes in-flight entries. Bubbles carry all-zero control bits.
//  Sits between decode (upstream, in_*) and execute (downstream, out_*).
// PARAMETERS
//  DATA_W   32  width of each operand, immediate and data field
//  REG_AW   5   destination register index width
//  OP_W     6   opcode width
//  NUM_SRC  3   operand channels carried (rs, rt, rd data); packed bus, channel k at [k*DATA_W +: DATA_W]
//  CNT_W    16  stall-cycle counter width
// PORTS
//  clk           in   1                 clock, all state on posedge
//  reset         in   1                 synchronous, active-high
//  flush         in   1                 squash all held entries this cycle
//  in_valid      in   1                 decode presents an instruction
//  in_ready      out  1                 block can accept (registered, = ~skid_valid)
//  in_opcode     in   OP_W              opcode
//  in_src_data   in   NUM_SRC*DATA_W    operand data channels
//  in_rd         in   REG_AW            destination register
//  in_imm        in   DATA_W            sign-extended immediate
//  in_mem_read   in   1                 control: load
//  in_mem_write  in   1                 control: store
//  in_reg_write  in   1                 control: writeback enable
//  out_valid     out  1                 EX stage holds a valid instruction
//  out_ready     in   1                 EX consumes this cycle
//  out_opcode / out_src_data / out_rd / out_imm    out  same widths as inputs
//  out_mem_read / out_mem_write / out_reg_write    out  1  forced 0 when out_valid=0
//  stall_cnt     out  CNT_W             cycles with out_valid & ~out_ready, saturating
// BEHAVIOUR
//  Single clock domain: clk. Reset is synchronous and active-high (reset sampled on posedge clk).
//  Priority: reset > flush > handshake.
//  - reset: all outputs 0, in_ready=1, stall_cnt=0, state EMPTY.
//  Storage: main slot M (drives out_*), skid slot S; accept = in_valid & in_ready; pop = out_valid & out_ready.
//  States / transitions:
//   EMPTY -- accept -> M<=in, MAIN.
//   MAIN:
//    - accept&pop: M<=in, stay MAIN.
//    - accept&~pop: S<=in, BOTH.
//    - ~accept&pop: EMPTY.
//    - else hold.
//   BOTH (in_ready=0):
//    - pop: M<=S, MAIN.
//    - else hold, no data field changes.
//  Latency: 1 cycle in->out when EMPTY. Throughput: 1 instr/cycle while out_ready=1. No input lost or duplicated.
//  flush: next state EMPTY, S and M valid cleared. An accept in the same cycle is discarded (upstream sees it consumed).
//   in_ready=1 in the following cycle.
//  Bubble: out_valid=0 forces out_mem_read/out_mem_write/out_reg_write to 0. Data fields keep last M content.
//  in_ready depends only on state (no in->out combinational path); out_valid likewise.
//  stall_cnt: +1 each cycle out_valid & ~out_ready; holds at 2^CNT_W-1; cleared only by reset; unaffected by flush.
//  Width rules: all fields copied verbatim, no extension or truncation inside the block.
// STRUCTURE
//  pipe_pkg: OP_W, REG_AW defaults; state localparams EMPTY=2'd0, MAIN=2'd1, BOTH=2'd2.
//  pipe_pkg: packed field layout helper (payload width = OP_W+NUM_SRC*DATA_W+REG_AW+DATA_W+3).
//  Sub-module pipe_slot: one payload register + valid bit with load, clear, sync reset. Instantiated twice (M, S).
//  Top holds FSM, muxes M source (in vs S), control-bit gating, stall counter.
// TESTING
//  1 reset held 2 cycles mid-traffic -> out_valid=0, all out_* 0, in_ready=1, stall_cnt=0 next cycle.
//  2 stream of 8 instrs, out_ready=1 -> each appears 1 cycle later, in order, out_valid continuous.
//  3 out_ready=0 while sending A,B -> A on out, B in skid, in_ready=0.
//    Then out_ready=1 -> A pops, B next cycle, in_ready=1; stall_cnt counts held cycles.
//  4 state BOTH + flush with in_valid=1 (C) -> next cycle out_valid=0, controls 0; C never appears; in_ready=1.
//  5 load with mem_read=1 then gap -> during gap out_mem_read=0, out_valid=0, out_src_data unchanged.
//  6 CNT_W=4, out_ready=0 for 20 cycles with valid M -> stall_cnt stops at 15; flush does not clear it.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID->EX elastic register: default widths, FSM states
// and the packed payload width helper.
package pipe_pkg;

  localparam int OP_W_DEF   = 6;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } state_t;

  // Payload layout, MSB first: opcode | src data | rd | imm | mem_read | mem_write | reg_write
  function automatic int payload_w(input int op_w, input int num_src,
                                   input int data_w, input int reg_aw);
    return op_w + num_src * data_w + reg_aw + data_w + 3;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: payload register plus valid bit.
// Clear drops the valid bit but keeps the payload, so bubbles show the last content.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/id_ex_elastic_reg.sv
// ID->EX pipeline register with a 2-entry skid buffer, flush and a saturating stall counter.
//  state | meaning
//  EMPTY | no instruction held, out_valid=0
//  MAIN  | main slot holds the EX instruction
//  BOTH  | main and skid slots full, in_ready=0
module id_ex_elastic_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = pipe_pkg::REG_AW_DEF,
  parameter int OP_W    = pipe_pkg::OP_W_DEF,
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_opcode,
  input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic                      in_reg_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           out_opcode,
  output logic [NUM_SRC*DATA_W-1:0] out_src_data,
  output logic [REG_AW-1:0]         out_rd,
  output logic [DATA_W-1:0]         out_imm,
  output logic                      out_mem_read,
  output logic                      out_mem_write,
  output logic                      out_reg_write,
  output logic [CNT_W-1:0]          stall_cnt
);
  import pipe_pkg::*;

  localparam int PW = payload_w(OP_W, NUM_SRC, DATA_W, REG_AW);

  state_t        state_q, state_d;
  logic          accept, pop;
  logic          m_load, m_clear, s_load, s_clear;
  logic          m_valid, s_valid;
  logic [PW-1:0] in_pl, m_d, m_q, s_q;
  logic          m_mem_read, m_mem_write, m_reg_write;

  assign in_pl = {in_opcode, in_src_data, in_rd, in_imm, in_mem_read, in_mem_write, in_reg_write};

  // Handshake outputs come straight from slot flops: no input-to-output path.
  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:   if (accept) state_d = MAIN;
        MAIN: begin
          if (accept && !pop)      state_d = BOTH;
          else if (!accept && pop) state_d = EMPTY;
        end
        BOTH:    if (pop) state_d = MAIN;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_d     = (state_q == BOTH) ? s_q : in_pl;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: m_load = accept;
        MAIN: begin
          m_load  = accept & pop;
          s_load  = accept & ~pop;
          m_clear = ~accept & pop;
        end
        BOTH: begin
          m_load  = pop;
          s_clear = pop;
        end
        default: begin
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .q     (m_q),
    .valid (m_valid)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (s_load),
    .clear (s_clear),
    .d     (in_pl),
    .q     (s_q),
    .valid (s_valid)
  );

  assign {out_opcode, out_src_data, out_rd, out_imm, m_mem_read, m_mem_write, m_reg_write} = m_q;

  // Bubbles must never write memory or the register file.
  assign out_mem_read  = m_mem_read  & m_valid;
  assign out_mem_write = m_mem_write & m_valid;
  assign out_reg_write = m_reg_write & m_valid;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Randomized self-checking bench for id_ex_elastic_reg against a transaction-level queue model.
module tb_id_ex_elastic_reg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int OP_W    = 6;
  localparam int NUM_SRC = 3;
  localparam int CNT_W   = 4;
  localparam int PW      = OP_W + NUM_SRC * DATA_W + REG_AW + DATA_W + 3;
  localparam int OW      = 2 + CNT_W + PW;
  localparam int SRC_LSB = REG_AW + DATA_W + 3;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [PW-1:0] in_pl = '0;
  logic [OP_W-1:0] in_opcode, out_opcode;
  logic [NUM_SRC*DATA_W-1:0] in_src_data, out_src_data;
  logic [REG_AW-1:0] in_rd, out_rd;
  logic [DATA_W-1:0] in_imm, out_imm;
  logic in_mem_read, in_mem_write, in_reg_write;
  logic out_mem_read, out_mem_write, out_reg_write;
  logic [CNT_W-1:0] stall_cnt;

  logic [OW-1:0] obs, exp_o;
  logic [PW-1:0] mq[$];
  logic [PW-1:0] last_m = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  assign {in_opcode, in_src_data, in_rd, in_imm, in_mem_read, in_mem_write, in_reg_write} = in_pl;
  assign obs = {out_valid, in_ready, stall_cnt, out_opcode, out_src_data, out_rd, out_imm,
                out_mem_read, out_mem_write, out_reg_write};

  id_ex_elastic_reg #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_src_data(in_src_data), .in_rd(in_rd), .in_imm(in_imm),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_src_data(out_src_data), .out_rd(out_rd), .out_imm(out_imm),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [PW-1:0] rand_pl();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  // Advance one clock; the model sees this cycle's inputs, then forms the expected outputs.
  task automatic cycle();
    bit acc, pop, stall;
    acc   = in_valid && (mq.size() < 2);
    pop   = (mq.size() > 0) && out_ready;
    stall = (mq.size() > 0) && !out_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      last_m = '0;
      m_cnt  = '0;
    end else begin
      if (stall && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
      if (flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(in_pl);
      end
      if (mq.size() > 0) last_m = mq[0];
    end
    exp_o = {mq.size() > 0, mq.size() < 2, m_cnt, last_m[PW-1:3],
             (mq.size() > 0) ? last_m[2:0] : 3'b000};
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    tests++;
    if (obs !== exp_o || obs !== {2'b01, {(OW-2){1'b0}}}) begin
      fails++; $display("FAIL reset_init got %h exp %h", obs, exp_o);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_pl = rand_pl(); cycle(); end
    do_reset(2);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== '0 || obs !== exp_o ||
        out_src_data !== '0 || out_reg_write !== 1'b0) begin
      fails++; $display("FAIL reset_mid got %h exp %h", obs, exp_o);
    end
  endtask

  task automatic test_stream();
    logic [PW-1:0] sent[8];
    do_reset(1);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sent[i] = rand_pl(); in_pl = sent[i];
      cycle();
      tests++;
      if (obs !== exp_o || out_valid !== 1'b1 ||
          {out_opcode, out_src_data, out_rd, out_imm} !== sent[i][PW-1:3]) begin
        fails++; $display("FAIL stream[%0d] got %h exp %h", i, obs, exp_o);
      end
    end
    in_valid = 1'b0;
    cycle();
    tests++;
    if (out_valid !== 1'b0 || obs !== exp_o) begin
      fails++; $display("FAIL stream_drain got %h exp %h", obs, exp_o);
    end
  endtask

  task automatic test_skid();
    logic [PW-1:0] a, b;
    do_reset(1);
    a = rand_pl(); b = rand_pl();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pl = a; cycle();
    in_pl = b; cycle();
    in_valid = 1'b0; in_pl = rand_pl();
    tests++;
    if (obs !== exp_o || in_ready !== 1'b0 || out_valid !== 1'b1 ||
        {out_opcode, out_src_data, out_rd, out_imm} !== a[PW-1:3]) begin
      fails++; $display("FAIL skid_hold got %h exp %h", obs, exp_o);
    end
    cycle(); cycle();
    tests++;
    if (stall_cnt !== 4'd3 || obs !== exp_o) begin
      fails++; $display("FAIL skid_stall_cnt got %0d exp 3", stall_cnt);
    end
    out_ready = 1'b1; cycle();
    tests++;
    if (obs !== exp_o || in_ready !== 1'b1 ||
        {out_opcode, out_src_data, out_rd, out_imm} !== b[PW-1:3]) begin
      fails++; $display("FAIL skid_pop_b got %h exp %h", obs, exp_o);
    end
    cycle();
    tests++;
    if (out_valid !== 1'b0 || obs !== exp_o) begin
      fails++; $display("FAIL skid_empty got %h exp %h", obs, exp_o);
    end
  endtask

  task automatic test_flush_both();
    do_reset(1);
    out_ready = 1'b0; in_valid = 1'b1;
    in_pl = rand_pl(); cycle();
    in_pl = rand_pl(); cycle();
    in_pl = rand_pl() | 3'b111; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (obs !== exp_o || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {out_mem_read, out_mem_write, out_reg_write} !== 3'b000) begin
      fails++; $display("FAIL flush_both got %h exp %h", obs, exp_o);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (out_valid !== 1'b0 || obs !== exp_o) begin
        fails++; $display("FAIL flush_no_c[%0d] got %h exp %h", i, obs, exp_o);
      end
    end
  endtask

  task automatic test_bubble();
    logic [PW-1:0] ld;
    do_reset(1);
    ld = rand_pl(); ld[2] = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_pl = ld; cycle();
    tests++;
    if (out_mem_read !== 1'b1 || obs !== exp_o) begin
      fails++; $display("FAIL bubble_load got %h exp %h", obs, exp_o);
    end
    in_valid = 1'b0; in_pl = rand_pl();
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests++;
      if (out_valid !== 1'b0 || out_mem_read !== 1'b0 || obs !== exp_o ||
          out_src_data !== ld[SRC_LSB +: NUM_SRC*DATA_W]) begin
        fails++; $display("FAIL bubble_gap[%0d] got %h exp %h", i, obs, exp_o);
      end
    end
  endtask

  task automatic test_stall_sat();
    do_reset(1);
    out_ready = 1'b1; in_valid = 1'b1; in_pl = rand_pl(); cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      tests++;
      if (stall_cnt !== ((i + 1 > 15) ? 4'd15 : 4'(i + 1)) || obs !== exp_o) begin
        fails++; $display("FAIL stall_sat[%0d] got %0d exp %0d", i, stall_cnt, (i + 1 > 15) ? 15 : i + 1);
      end
    end
    flush = 1'b1; cycle(); flush = 1'b0; cycle();
    tests++;
    if (stall_cnt !== 4'd15 || out_valid !== 1'b0 || obs !== exp_o) begin
      fails++; $display("FAIL stall_after_flush got %0d exp 15", stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      in_pl     = rand_pl();
      cycle();
      tests++;
      if (obs !== exp_o) begin
        fails++; $display("FAIL random[%0d] got %h exp %h", i, obs, exp_o);
      end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush_both();
    test_bubble();
    test_stall_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
